// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard stall controller: stalls/bubbles the pipe for LOAD_LAT cycles, freezes on memory busy, flushes on taken branch.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating hazard_events counter (tied to 0 otherwise).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no hazard in progress; evaluate branch / hz each cycle
// S_STALL  | inside a multi-cycle load-use stall, cnt = stalls left
// S_MEMWAIT| pipe frozen on mem_busy; ret_state is what to resume as
module hazard_stall_ctrl #(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_decode,
    input  logic [REG_AW-1:0] rd_decode,
    input  logic              rs_used,
    input  logic              rd_used,
    input  logic [REG_AW-1:0] rdst_ex,
    input  logic              mem_read_ex,
    input  logic              pop_flags_ex,
    input  logic              mem_busy,
    input  logic              branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              freeze,
    output logic              flush_ifid,
    output logic [15:0]       hazard_events
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STALL   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    state_t     state, state_nxt;
    state_t     ret_state, ret_nxt;
    state_t     act_state;
    logic [3:0] cnt, cnt_nxt;
    logic       hz;
    logic       new_hz;
    logic       stall_c, bubble_c, freeze_c, flush_c;

    assign hz = mem_read_ex & ~pop_flags_ex &
                ((rs_used & (rdst_ex == rs_decode)) | (rd_used & (rdst_ex == rd_decode)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            cnt       <= 4'd0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        cnt_nxt   = cnt;
        act_state = state;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        freeze_c  = 1'b0;
        flush_c   = 1'b0;
        new_hz    = 1'b0;

        if (mem_busy) begin
            freeze_c  = 1'b1;
            state_nxt = S_MEMWAIT;
            if (state != S_MEMWAIT) begin
                ret_nxt = state;
            end
        end else begin
            // Leaving MEMWAIT acts as the saved state within the same cycle.
            if (state == S_MEMWAIT) begin
                act_state = ret_state;
            end
            state_nxt = act_state;
            ret_nxt   = S_IDLE;

            if (act_state == S_STALL) begin
                if (branch_taken) begin
                    flush_c   = 1'b1;
                    bubble_c  = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_nxt  = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = S_IDLE;
                    end
                end
            end else if (branch_taken) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (hz) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                new_hz   = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_nxt = S_STALL;
                    cnt_nxt   = LAT_M1;
                end
            end
        end
    end

    assign stall      = stall_c  & ~reset;
    assign bubble     = bubble_c & ~reset;
    assign freeze     = freeze_c & ~reset;
    assign flush_ifid = flush_c  & ~reset;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] hz_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hz_cnt <= 16'd0;
        end else if (new_hz && (hz_cnt != 16'hFFFF)) begin
            hz_cnt <= hz_cnt + 16'd1;
        end
    end

    assign hazard_events = reset ? 16'd0 : hz_cnt;
`else
    logic unused_new_hz;
    assign unused_new_hz = new_hz;
    assign hazard_events = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: four instances (LOAD_LAT 1..4) on shared inputs, checked every cycle
// against a remaining-stall-count model, plus directed scenarios with literal expectations.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rs_decode, rd_decode, rdst_ex;
    logic       rs_used, rd_used, mem_read_ex, pop_flags_ex, mem_busy, branch_taken;

    logic        stall_o  [4];
    logic        bubble_o [4];
    logic        freeze_o [4];
    logic        flush_o  [4];
    logic [15:0] hev_o    [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_stall_ctrl #(.REG_AW(3), .LOAD_LAT(g + 1)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .rs_decode    (rs_decode),
            .rd_decode    (rd_decode),
            .rs_used      (rs_used),
            .rd_used      (rd_used),
            .rdst_ex      (rdst_ex),
            .mem_read_ex  (mem_read_ex),
            .pop_flags_ex (pop_flags_ex),
            .mem_busy     (mem_busy),
            .branch_taken (branch_taken),
            .stall        (stall_o[g]),
            .bubble       (bubble_o[g]),
            .freeze       (freeze_o[g]),
            .flush_ifid   (flush_o[g]),
            .hazard_events(hev_o[g])
        );
    end

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat%0d: got %0h expected %0h at %0t", name, idx + 1, act, exp, $time);
        end
    endtask

    // Model: a hazard owes LOAD_LAT stall cycles; freeze pauses the debt, a branch cancels it.
    int m_rem [4] = '{default: 0};
    int m_cnt [4] = '{default: 0};

    always @(negedge clk) begin
        logic hz_m;
        logic e_st, e_bu, e_fr, e_fl;
        hz_m = mem_read_ex && !pop_flags_ex &&
               ((rs_used && rdst_ex == rs_decode) || (rd_used && rdst_ex == rd_decode));
        for (int i = 0; i < 4; i++) begin
            e_st = 0; e_bu = 0; e_fr = 0; e_fl = 0;
            if (!reset) begin
                if (mem_busy) e_fr = 1;
                else if (branch_taken) begin e_fl = 1; e_bu = 1; end
                else if (m_rem[i] > 0 || hz_m) begin e_st = 1; e_bu = 1; end
            end
            check("m_stall",  i, 16'(stall_o[i]),  16'(e_st));
            check("m_bubble", i, 16'(bubble_o[i]), 16'(e_bu));
            check("m_freeze", i, 16'(freeze_o[i]), 16'(e_fr));
            check("m_flush",  i, 16'(flush_o[i]),  16'(e_fl));
            check("m_events", i, hev_o[i], (reset || !PERF) ? 16'd0 : 16'(m_cnt[i]));
            if (reset) begin
                m_rem[i] = 0;
                m_cnt[i] = 0;
            end else if (!mem_busy) begin
                if (branch_taken) m_rem[i] = 0;
                else if (m_rem[i] > 0) m_rem[i]--;
                else if (hz_m) begin
                    m_rem[i] = i;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic hz_on();
        rdst_ex = 3'd3; rs_decode = 3'd3; rs_used = 1'b1; mem_read_ex = 1'b1;
    endtask

    task automatic idle(input int n);
        mem_read_ex = 0; rs_used = 0; rd_used = 0; pop_flags_ex = 0; mem_busy = 0; branch_taken = 0;
        repeat (n) nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; rs_decode = 0; rd_decode = 0; rdst_ex = 0;
        rs_used = 0; rd_used = 0; mem_read_ex = 0; pop_flags_ex = 0; mem_busy = 0; branch_taken = 0;
        hz_on();
        repeat (2) begin
            smp();
            for (int i = 0; i < 4; i++) begin
                check("rst_stall", i, 16'(stall_o[i]), 16'd0);
                check("rst_events", i, hev_o[i], 16'd0);
            end
            nxt();
        end
        reset = 0;
        idle(2);

        // Load-use on rs, LOAD_LAT=2 stalls exactly 2 cycles; LOAD_LAT=1 stalls one.
        hz_on();
        smp(); check("a_stall0", 1, 16'(stall_o[1]), 16'd1); check("a_bub0", 1, 16'(bubble_o[1]), 16'd1);
        check("a_stall0", 0, 16'(stall_o[0]), 16'd1);
        nxt(); mem_read_ex = 0;
        smp(); check("a_stall1", 1, 16'(stall_o[1]), 16'd1); check("a_stall1", 0, 16'(stall_o[0]), 16'd0);
        nxt();
        smp(); check("a_stall2", 1, 16'(stall_o[1]), 16'd0); check("a_bub2", 1, 16'(bubble_o[1]), 16'd0);
        check("a_events", 1, hev_o[1], PERF ? 16'd1 : 16'd0);
        nxt(); idle(4);

        // Flags pop or unused rs mask the hazard; rd path detects it.
        hz_on(); pop_flags_ex = 1;
        repeat (2) begin smp(); check("b_pop_stall", 1, 16'(stall_o[1]), 16'd0); nxt(); end
        pop_flags_ex = 0; rs_used = 0;
        repeat (2) begin smp(); check("b_rsu_bubble", 1, 16'(bubble_o[1]), 16'd0); nxt(); end
        rd_used = 1; rd_decode = 3'd3; rs_decode = 3'd5;
        smp(); check("b_rd_stall", 1, 16'(stall_o[1]), 16'd1);
        nxt(); idle(4);

        // LOAD_LAT=3 frozen for 2 cycles in its 2nd stall cycle; branch ignored while frozen.
        rd_decode = 3'd0; hz_on();
        smp(); check("c_stall0", 2, 16'(stall_o[2]), 16'd1);
        nxt(); mem_read_ex = 0; mem_busy = 1;
        smp(); check("c_frz1", 2, 16'(freeze_o[2]), 16'd1); check("c_stall1", 2, 16'(stall_o[2]), 16'd0);
        check("c_bub1", 2, 16'(bubble_o[2]), 16'd0);
        nxt(); branch_taken = 1;
        smp(); check("c_frz2", 2, 16'(freeze_o[2]), 16'd1); check("c_flush2", 2, 16'(flush_o[2]), 16'd0);
        nxt(); mem_busy = 0; branch_taken = 0;
        smp(); check("c_stall3", 2, 16'(stall_o[2]), 16'd1); check("c_frz3", 2, 16'(freeze_o[2]), 16'd0);
        nxt();
        smp(); check("c_stall4", 2, 16'(stall_o[2]), 16'd1);
        nxt();
        smp(); check("c_stall5", 2, 16'(stall_o[2]), 16'd0);
        nxt(); idle(4);

        // LOAD_LAT=3 aborted by a branch in its 2nd stall cycle.
        hz_on();
        smp(); check("d_stall0", 2, 16'(stall_o[2]), 16'd1);
        nxt(); mem_read_ex = 0; branch_taken = 1;
        smp(); check("d_flush1", 2, 16'(flush_o[2]), 16'd1); check("d_bub1", 2, 16'(bubble_o[2]), 16'd1);
        check("d_stall1", 2, 16'(stall_o[2]), 16'd0);
        nxt(); branch_taken = 0;
        smp(); check("d_stall2", 2, 16'(stall_o[2]), 16'd0); check("d_bub2", 2, 16'(bubble_o[2]), 16'd0);
        nxt(); idle(4);

        // Hazard and branch together: branch wins, no stall.
        hz_on(); branch_taken = 1;
        smp();
        for (int i = 0; i < 4; i++) begin
            check("e_flush", i, 16'(flush_o[i]), 16'd1);
            check("e_stall", i, 16'(stall_o[i]), 16'd0);
        end
        nxt(); mem_read_ex = 0; branch_taken = 0;
        smp(); check("e_stall_after", 3, 16'(stall_o[3]), 16'd0);
        nxt(); idle(4);

        // Reset in the 1st stall cycle of LOAD_LAT=4 leaves nothing behind.
        hz_on();
        smp(); check("f_stall0", 3, 16'(stall_o[3]), 16'd1);
        nxt(); mem_read_ex = 0; reset = 1;
        smp(); check("f_rst_stall", 3, 16'(stall_o[3]), 16'd0); check("f_rst_bub", 3, 16'(bubble_o[3]), 16'd0);
        check("f_rst_events", 3, hev_o[3], 16'd0);
        nxt(); reset = 0;
        repeat (3) begin
            smp(); check("f_post_stall", 3, 16'(stall_o[3]), 16'd0); check("f_post_events", 3, hev_o[3], 16'd0);
            nxt();
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..15; total stall cycles per load-use hazard.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports rs_decode, rd_decode  input  REG_AW  source and destination register addresses in decode.
REQ-006 SHALL have ports rs_used, rd_used  input  1  decode instruction reads rs / reads rd (jmp, std, out, ALU ops).
REQ-007 SHALL have port rdst_ex  input  REG_AW  destination register of the instruction in EX.
REQ-008 SHALL have ports mem_read_ex, pop_flags_ex  input  1  EX instruction is a memory read / a flags pop.
REQ-009 SHALL have port mem_busy  input  1  data memory not ready; whole pipe freezes.
REQ-010 SHALL have port branch_taken  input  1  EX resolved a taken branch or jump.
REQ-011 SHALL have ports stall, bubble, freeze, flush_ifid  output  1  hold PC and IF/ID / insert NOP into ID/EX / hold all pipe registers / clear IF/ID.
REQ-012 SHALL have port hazard_events  output  16  count of load-use hazards detected.

Function
REQ-013 SHALL compute hz = mem_read_ex & !pop_flags_ex & ((rs_used & rdst_ex==rs_decode) | (rd_used & rdst_ex==rd_decode)), combinationally.
REQ-014 SHALL implement states IDLE, STALL, MEMWAIT, with a 4-bit remaining-stall counter cnt.
REQ-015 IDLE, mem_busy=1: freeze=1, all other outputs 0; next MEMWAIT.
REQ-016 IDLE, mem_busy=0, branch_taken=1: flush_ifid=1, bubble=1, stall=0; stay IDLE; hz ignored.
REQ-017 IDLE, mem_busy=0, branch_taken=0, hz=1: stall=1, bubble=1 in the same cycle; if LOAD_LAT>1, next STALL with cnt=LOAD_LAT-1, else stay IDLE.
REQ-018 STALL: stall=1, bubble=1; decrement cnt each cycle; at cnt==1, next IDLE; hz not re-evaluated while in STALL.
REQ-019 STALL, branch_taken=1 and mem_busy=0: abort stall, flush_ifid=1, bubble=1, stall=0, next IDLE, cnt cleared.
REQ-020 STALL, mem_busy=1: freeze=1, stall=0, bubble=0; cnt held; next MEMWAIT with return state STALL.
REQ-021 MEMWAIT: freeze=1 while mem_busy=1, all else 0; branch_taken ignored (upstream holds it); on mem_busy=0 that cycle behaves as the saved return state (IDLE or STALL) in the same cycle.
REQ-022 Priority each cycle: reset > mem_busy > branch_taken > hz / STALL.
REQ-023 Outputs stall, bubble, flush_ifid, freeze SHALL be mutually consistent: freeze=1 implies the other three are 0.
REQ-024 Total stall cycles per uninterrupted hazard SHALL equal LOAD_LAT exactly.

Reset
REQ-025 While reset=1, all outputs SHALL be 0, including combinational ones.
REQ-026 On a clock edge with reset=1: state IDLE, cnt 0, return state IDLE, hazard_events 0.
REQ-027 Reset asserted mid-STALL or mid-MEMWAIT SHALL abandon the operation with no residual stall after deassertion.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: hazard_events increments by 1 on each cycle entering a new hazard (REQ-017 condition), saturating at 16'hFFFF.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: counter logic absent, hazard_events tied to 0; all other behaviour identical.

Verification
REQ-030 LOAD_LAT=2, rdst_ex=3, rs_decode=3, rs_used=1, mem_read_ex=1 -> stall=bubble=1 for exactly 2 cycles, then 0; hazard_events=1.
REQ-031 Same stimulus with pop_flags_ex=1, or rs_used=0 -> stall=bubble=0 throughout.
REQ-032 LOAD_LAT=3, mem_busy=1 for 2 cycles during the 2nd stall cycle -> freeze=1 for 2 cycles, then stall resumes for the 2 remaining cycles (3 stall cycles total).
REQ-033 LOAD_LAT=3, branch_taken=1 in the 2nd stall cycle -> flush_ifid=1 that cycle, stall=0 from that cycle onward, state IDLE.
REQ-034 hz=1 and branch_taken=1 in the same cycle -> flush_ifid=1, bubble=1, stall=0; hazard_events unchanged.
REQ-035 reset=1 in the 1st stall cycle with LOAD_LAT=4 -> all outputs 0 that cycle and after deassertion (hz=0), hazard_events=0.
